// File: rtl/tetris_line_clear_if.sv
// Bus between the line-clear scanner, the external row mux, the PIO inputs and display logic.
// The master side drives the requests and the selected row word; the slave is the scanner.
interface tetris_line_clear_if #(
  parameter int unsigned ROWS    = 20,
  parameter int unsigned CELLS   = 10,
  parameter int unsigned CELL_W  = 3,
  parameter int unsigned SCORE_W = 24,
  parameter int unsigned LINES_W = 16
) ();

  localparam int unsigned SelW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                      start;
  logic                      clear_stats;
  logic [CELLS*CELL_W-1:0]   row_in;
  logic [SelW-1:0]           row_sel;
  logic                      busy;
  logic                      done;
  logic [ROWS-1:0]           full_mask;
  logic [2:0]                lines_cleared;
  logic [SCORE_W-1:0]        score;
  logic [LINES_W-1:0]        lines_total;

  modport master (
    output start,
    output clear_stats,
    output row_in,
    input  row_sel,
    input  busy,
    input  done,
    input  full_mask,
    input  lines_cleared,
    input  score,
    input  lines_total
  );

  modport slave (
    input  start,
    input  clear_stats,
    input  row_in,
    output row_sel,
    output busy,
    output done,
    output full_mask,
    output lines_cleared,
    output score,
    output lines_total
  );

endinterface

// File: rtl/tetris_line_clear.sv
// Scans every board row through an external mux, flags full rows and accumulates the
// standard Tetris line score and the running line total (both saturating).
module tetris_line_clear #(
  parameter int unsigned ROWS    = 20,
  parameter int unsigned CELLS   = 10,
  parameter int unsigned CELL_W  = 3,
  parameter int unsigned SCORE_W = 24,
  parameter int unsigned LINES_W = 16
) (
  input logic                clk,
  input logic                reset_n,
  tetris_line_clear_if.slave bus
);

  localparam int unsigned SelW = (ROWS > 1) ? $clog2(ROWS) : 1;
  // Sum is wide enough for the largest point value even when SCORE_W is narrow.
  localparam int unsigned SumW = ((SCORE_W > 11) ? SCORE_W : 11) + 1;
  localparam int unsigned TotW = LINES_W + 1;
  localparam logic [SelW-1:0] LastRow = SelW'(ROWS - 1);

  typedef enum logic [1:0] {StIdle, StScan, StScore, StDone} state_e;

  state_e               state_q, state_d;
  logic [SelW-1:0]      row_sel_q, row_sel_d;
  logic [ROWS-1:0]      full_mask_q, full_mask_d;
  logic [2:0]           count_q, count_d;
  logic [2:0]           lines_q, lines_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [LINES_W-1:0]   total_q, total_d;

  logic                 row_full;
  logic [10:0]          points;
  logic [SumW-1:0]      score_sum;
  logic [SCORE_W-1:0]   score_sat;
  logic [TotW-1:0]      total_sum;
  logic [LINES_W-1:0]   total_sat;

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < CELLS; c++) begin
      if (bus.row_in[c*CELL_W +: CELL_W] == '0) begin
        row_full = 1'b0;
      end
    end
  end

  always_comb begin
    unique case (count_q)
      3'd0:    points = 11'd0;
      3'd1:    points = 11'd40;
      3'd2:    points = 11'd100;
      3'd3:    points = 11'd300;
      default: points = 11'd1200;
    endcase
  end

  always_comb begin
    score_sum = SumW'(score_q) + SumW'(points);
    score_sat = (score_sum > SumW'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}}
                                                      : score_sum[SCORE_W-1:0];
    total_sum = TotW'(total_q) + TotW'(count_q);
    total_sat = total_sum[LINES_W] ? {LINES_W{1'b1}} : total_sum[LINES_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    row_sel_d   = row_sel_q;
    full_mask_d = full_mask_q;
    count_d     = count_q;
    lines_d     = lines_q;
    score_d     = score_q;
    total_d     = total_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d     = StScan;
          row_sel_d   = '0;
          full_mask_d = '0;
          count_d     = '0;
        end
      end
      StScan: begin
        if (row_full) begin
          full_mask_d = full_mask_q | (ROWS'(1) << row_sel_q);
          if (count_q != 3'd7) begin
            count_d = count_q + 3'd1;
          end
        end
        if (row_sel_q == LastRow) begin
          state_d = StScore;
        end else begin
          row_sel_d = row_sel_q + SelW'(1);
        end
      end
      StScore: begin
        lines_d = count_q;
        score_d = score_sat;
        total_d = total_sat;
        state_d = StDone;
      end
      StDone: begin
        row_sel_d = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Placed last so a clear in the SCORE cycle discards that scan's points.
    if (bus.clear_stats) begin
      score_d = '0;
      total_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      row_sel_q   <= '0;
      full_mask_q <= '0;
      count_q     <= '0;
      lines_q     <= '0;
      score_q     <= '0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      row_sel_q   <= row_sel_d;
      full_mask_q <= full_mask_d;
      count_q     <= count_d;
      lines_q     <= lines_d;
      score_q     <= score_d;
      total_q     <= total_d;
    end
  end

  assign bus.row_sel       = row_sel_q;
  assign bus.busy          = (state_q != StIdle);
  assign bus.done          = (state_q == StDone);
  assign bus.full_mask     = full_mask_q;
  assign bus.lines_cleared = lines_q;
  assign bus.score         = score_q;
  assign bus.lines_total   = total_q;

  a_done_busy: assert property (@(posedge clk) disable iff (!reset_n) bus.done |-> bus.busy);
  a_row_range: assert property (@(posedge clk) disable iff (!reset_n) row_sel_q <= LastRow);

endmodule

// File: tb/tb_tetris_line_clear.sv
// Directed bench: table of board patterns with hand-computed results, run on a default
// instance and an 8-bit-score instance, plus reset-mid-scan sequence.
module tb_tetris_line_clear;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        clear_stats;
  logic [29:0] board [20];

  always #5 clk = ~clk;

  tetris_line_clear_if #(.ROWS(20), .CELLS(10), .CELL_W(3), .SCORE_W(24), .LINES_W(16)) bus ();
  tetris_line_clear_if #(.ROWS(20), .CELLS(10), .CELL_W(3), .SCORE_W(8), .LINES_W(16)) bus8 ();

  assign bus.start        = start;
  assign bus.clear_stats  = clear_stats;
  assign bus.row_in       = board[bus.row_sel];
  assign bus8.start       = start;
  assign bus8.clear_stats = clear_stats;
  assign bus8.row_in      = board[bus8.row_sel];

  tetris_line_clear #(.ROWS(20), .CELLS(10), .CELL_W(3), .SCORE_W(24), .LINES_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  tetris_line_clear #(.ROWS(20), .CELLS(10), .CELL_W(3), .SCORE_W(8), .LINES_W(16)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus8)
  );

  typedef struct {
    logic [19:0] rows;       // rows loaded with word, others empty
    logic [29:0] word;
    int          clr_at;     // -1 none, 0 with start, n = scan-relative cycle
    int          mid_start;  // 0 none, n = extra start pulse at that cycle
    logic [19:0] exp_mask;
    int          exp_lines;
    int          exp_score;
    int          exp_score8;
    int          exp_total;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " row_sel"}, 64'(bus.row_sel), 64'd0);
    chk({tag, " busy"}, 64'(bus.busy), 64'd0);
    chk({tag, " done"}, 64'(bus.done), 64'd0);
    chk({tag, " full_mask"}, 64'(bus.full_mask), 64'd0);
    chk({tag, " lines_cleared"}, 64'(bus.lines_cleared), 64'd0);
    chk({tag, " score"}, 64'(bus.score), 64'd0);
    chk({tag, " lines_total"}, 64'(bus.lines_total), 64'd0);
    chk({tag, " score8"}, 64'(bus8.score), 64'd0);
  endtask

  task automatic apply(input string tag, input vec_t v);
    int first_done = 0;
    int done_cnt   = 0;
    int busy_cnt   = 0;
    for (int r = 0; r < 20; r++) board[r] = v.rows[r] ? v.word : 30'd0;
    @(negedge clk);
    start       = 1'b1;
    clear_stats = (v.clr_at == 0);
    @(negedge clk);
    start       = 1'b0;
    clear_stats = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (first_done == 0) first_done = n;
      end
      start       = (n == v.mid_start);
      clear_stats = (n == v.clr_at);
      @(negedge clk);
    end
    start       = 1'b0;
    clear_stats = 1'b0;
    chk({tag, " done cycle"}, 64'(first_done), 64'd22);
    chk({tag, " done count"}, 64'(done_cnt), 64'd1);
    chk({tag, " busy cycles"}, 64'(busy_cnt), 64'd22);
    chk({tag, " row_sel idle"}, 64'(bus.row_sel), 64'd0);
    chk({tag, " full_mask"}, 64'(bus.full_mask), 64'(v.exp_mask));
    chk({tag, " lines_cleared"}, 64'(bus.lines_cleared), 64'(v.exp_lines));
    chk({tag, " score"}, 64'(bus.score), 64'(v.exp_score));
    chk({tag, " lines_total"}, 64'(bus.lines_total), 64'(v.exp_total));
    chk({tag, " score8"}, 64'(bus8.score), 64'(v.exp_score8));
    chk({tag, " full_mask8"}, 64'(bus8.full_mask), 64'(v.exp_mask));
    chk({tag, " lines_total8"}, 64'(bus8.lines_total), 64'(v.exp_total));
  endtask

  vec_t vecs [10];
  vec_t v_after;

  initial begin
    //            rows       word          clr mid  mask      ln score s8   total
    vecs[0] = '{20'h00000, 30'h00000000, -1, 0, 20'h00000, 0, 0,    0,   0};
    vecs[1] = '{20'hC0000, 30'h3FFFFFFF, -1, 0, 20'hC0000, 2, 100,  100, 2};
    vecs[2] = '{20'hF0000, 30'h09249249,  0, 0, 20'hF0000, 4, 1200, 255, 4};
    vecs[3] = '{20'hF0000, 30'h09249249, -1, 0, 20'hF0000, 4, 2400, 255, 8};
    vecs[4] = '{20'h00020, 30'h3FFFFFF8, -1, 5, 20'h00000, 0, 2400, 255, 8};
    vecs[5] = '{20'h000FF, 30'h3FFFFFFF, -1, 0, 20'h000FF, 7, 3600, 255, 15};
    vecs[6] = '{20'h00001, 30'h3FFFFFFF, -1, 0, 20'h00001, 1, 3640, 255, 16};
    vecs[7] = '{20'h80402, 30'h3FFFFFFF, -1, 0, 20'h80402, 3, 3940, 255, 19};
    vecs[8] = '{20'hF0000, 30'h09249249, 21, 0, 20'hF0000, 4, 0,    0,   0};
    vecs[9] = '{20'hFFF00, 30'h24924924, -1, 0, 20'hFFF00, 7, 1200, 255, 7};
    v_after = '{20'hC0000, 30'h3FFFFFFF, -1, 0, 20'hC0000, 2, 100,  100, 2};

    reset_n     = 1'b0;
    start       = 1'b0;
    clear_stats = 1'b0;
    for (int r = 0; r < 20; r++) board[r] = 30'd0;
    repeat (2) @(negedge clk);
    chk_zero("in reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk_zero("after reset");

    for (int i = 0; i < 10; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Reset mid-scan: outputs clear immediately, no done pulse afterwards.
    for (int r = 0; r < 20; r++) board[r] = (r >= 18) ? 30'h3FFFFFFF : 30'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid-scan busy before reset", 64'(bus.busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_zero("mid-scan reset");
    @(negedge clk);
    reset_n = 1'b1;
    begin
      int dn = 0;
      int bz = 0;
      for (int n = 0; n < 30; n++) begin
        if (bus.done) dn++;
        if (bus.busy) bz++;
        @(negedge clk);
      end
      chk("post-reset done pulses", 64'(dn), 64'd0);
      chk("post-reset busy cycles", 64'(bz), 64'd0);
    end
    apply("after reset scan", v_after);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
